viral_job_dispatcher: RTL and testbench

VIRAL_JOB_DISPATCHER -- requirements
Module: viral_job_dispatcher

---
 rtl/viral_job_dispatcher.sv | 124 ++++++++++++
 tb/tb_viral_job_dispatcher.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/viral_job_dispatcher.sv
// Viral job dispatcher: queues sorter index sets and hands each one to the
// next free FragFetcher channel, round-robin, as a one-cycle start pulse.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   i_idxs_ready     sorter presents an index set this cycle
//   i_idxs           index set, index 0 in the LSBs
//   o_ready_to_rcv   queue not full (combinational)
//   o_ch_idxs        payload of the most recently dispatched job (all channels)
//   o_ch_start       one-hot, single-cycle job start per channel
//   i_ch_done        per-channel job-complete pulse
//   o_ch_busy        per-channel unfinished-job flag
//   o_count          number of queued (not yet dispatched) jobs
//   o_overflow       sticky: a set arrived while the queue was full
//   o_idle           queue empty and no channel busy (combinational)
module viral_job_dispatcher #(
  parameter int unsigned COMPRESSION_FACTOR = 16,
  parameter int unsigned INDEX_LENGTH       = 16,
  parameter int unsigned DEPTH              = 4,
  parameter int unsigned NUM_CH             = 2
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  input  logic                                       i_idxs_ready,
  input  logic [COMPRESSION_FACTOR*INDEX_LENGTH-1:0] i_idxs,
  output logic                                       o_ready_to_rcv,
  output logic [COMPRESSION_FACTOR*INDEX_LENGTH-1:0] o_ch_idxs,
  output logic [NUM_CH-1:0]                          o_ch_start,
  input  logic [NUM_CH-1:0]                          i_ch_done,
  output logic [NUM_CH-1:0]                          o_ch_busy,
  output logic [$clog2(DEPTH):0]                     o_count,
  output logic                                       o_overflow,
  output logic                                       o_idle
);

  localparam int unsigned DATA_W = COMPRESSION_FACTOR * INDEX_LENGTH;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CH_W-1:0]   last_grant;

  logic              full;
  logic              push;
  logic              pop;
  logic [NUM_CH-1:0] eligible;
  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  logic [NUM_CH-1:0] grant_oh;
  logic [NUM_CH-1:0] done_clr;

  // Queue status; a pop in the same cycle never makes room for a push.
  assign full           = (o_count == CNT_W'(DEPTH));
  assign o_ready_to_rcv = ~full;
  assign o_idle         = (o_count == '0) && (o_ch_busy == '0);
  assign push           = i_idxs_ready && !full;

  // A channel is free only once its start pulse has gone and it is not busy.
  assign eligible = ~o_ch_busy & ~o_ch_start;

  // Done is honoured only for a busy channel outside its start cycle.
  assign done_clr = i_ch_done & o_ch_busy & ~o_ch_start;

  // Round-robin search beginning one past the last granted channel.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      logic [CH_W-1:0] cand;
      cand = CH_W'((32'(last_grant) + 32'd1 + i) % NUM_CH);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign pop      = (o_count != '0) && grant_found;
  assign grant_oh = pop ? (NUM_CH'(1) << grant_idx) : '0;

  // Queue storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= i_idxs;
    end
  end

  // Pointers, occupancy, dispatch outputs and the sticky overflow flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr       <= '0;
      rptr       <= '0;
      o_count    <= '0;
      o_ch_start <= '0;
      o_ch_busy  <= '0;
      o_ch_idxs  <= '0;
      o_overflow <= 1'b0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr       <= rptr + PTR_W'(1);
        o_ch_idxs  <= mem[rptr];
        last_grant <= grant_idx;
      end
      if (push && !pop) begin
        o_count <= o_count + CNT_W'(1);
      end else if (pop && !push) begin
        o_count <= o_count - CNT_W'(1);
      end
      if (i_idxs_ready && full) begin
        o_overflow <= 1'b1;
      end
      o_ch_start <= grant_oh;
      o_ch_busy  <= (o_ch_busy & ~done_clr) | grant_oh;
    end
  end

endmodule

// File: tb/tb_viral_job_dispatcher.sv
// Directed bench for viral_job_dispatcher with default parameters
// (16x16-bit indexes, DEPTH=4, NUM_CH=2).
module tb_viral_job_dispatcher;

  localparam int unsigned W = 256;

  logic         clk;
  logic         rstn;
  logic         i_idxs_ready;
  logic [W-1:0] i_idxs;
  logic         o_ready_to_rcv;
  logic [W-1:0] o_ch_idxs;
  logic [1:0]   o_ch_start;
  logic [1:0]   i_ch_done;
  logic [1:0]   o_ch_busy;
  logic [2:0]   o_count;
  logic         o_overflow;
  logic         o_idle;

  int total = 0;
  int bad   = 0;

  viral_job_dispatcher dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_idxs_ready   (i_idxs_ready),
    .i_idxs         (i_idxs),
    .o_ready_to_rcv (o_ready_to_rcv),
    .o_ch_idxs      (o_ch_idxs),
    .o_ch_start     (o_ch_start),
    .i_ch_done      (i_ch_done),
    .o_ch_busy      (o_ch_busy),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .o_idle         (o_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct index set per tag: index j holds {tag, j}.
  function automatic logic [W-1:0] mk(input int tag);
    logic [W-1:0] v;
    v = '0;
    for (int j = 0; j < 16; j++) v[j*16 +: 16] = 16'((tag << 8) | j);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_idxs_ready = 1'b0;
    i_idxs       = '0;
    i_ch_done    = 2'b00;
    rstn         = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  // Pushes tags first..last on consecutive edges, then deasserts valid.
  task automatic push_run(input int first, input int last);
    for (int t = first; t <= last; t++) begin
      i_idxs_ready = 1'b1;
      i_idxs       = mk(t);
      step();
    end
    i_idxs_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (o_ch_start !== 2'b00) begin bad++; $display("FAIL reset_start got=%b exp=00", o_ch_start); end
    total++; if (o_ch_busy !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b exp=00", o_ch_busy); end
    total++; if (o_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", o_overflow); end
    total++; if (o_idle !== 1'b1 || o_ready_to_rcv !== 1'b1) begin bad++; $display("FAIL reset_idle_ready got=%b%b exp=11", o_idle, o_ready_to_rcv); end
    total++; if (o_ch_idxs !== '0) begin bad++; $display("FAIL reset_idxs got=%h exp=0", o_ch_idxs); end
  endtask

  task automatic test_single_job();
    do_reset();
    push_run(1, 1);
    total++; if (o_count !== 3'd1 || o_ch_start !== 2'b00) begin bad++; $display("FAIL single_no_bypass got count=%0d start=%b exp count=1 start=00", o_count, o_ch_start); end
    total++; if (o_idle !== 1'b0) begin bad++; $display("FAIL single_idle_low got=%b exp=0", o_idle); end
    step();
    total++; if (o_ch_start !== 2'b01 || o_ch_busy !== 2'b01) begin bad++; $display("FAIL single_start got start=%b busy=%b exp 01/01", o_ch_start, o_ch_busy); end
    total++; if (o_ch_idxs !== mk(1)) begin bad++; $display("FAIL single_idxs got=%h exp=%h", o_ch_idxs, mk(1)); end
    total++; if (o_count !== 3'd0) begin bad++; $display("FAIL single_count got=%0d exp=0", o_count); end
    step();
    total++; if (o_ch_start !== 2'b00 || o_ch_busy !== 2'b01 || o_ch_idxs !== mk(1)) begin bad++; $display("FAIL single_pulse_once got start=%b busy=%b exp 00/01 idxs held", o_ch_start, o_ch_busy); end
    i_ch_done = 2'b01;
    step();
    i_ch_done = 2'b00;
    total++; if (o_ch_busy !== 2'b00 || o_idle !== 1'b1) begin bad++; $display("FAIL single_done got busy=%b idle=%b exp 00/1", o_ch_busy, o_idle); end
  endtask

  task automatic test_round_robin();
    do_reset();
    i_idxs_ready = 1'b1; i_idxs = mk(10); step();
    i_idxs = mk(11); step();
    total++; if (o_ch_start !== 2'b01 || o_ch_idxs !== mk(10)) begin bad++; $display("FAIL rr_a got start=%b idxs=%h exp 01 A", o_ch_start, o_ch_idxs); end
    i_idxs = mk(12); step();
    i_idxs_ready = 1'b0;
    total++; if (o_ch_start !== 2'b10 || o_ch_idxs !== mk(11)) begin bad++; $display("FAIL rr_b got start=%b idxs=%h exp 10 B", o_ch_start, o_ch_idxs); end
    total++; if (o_count !== 3'd1 || o_ch_busy !== 2'b11) begin bad++; $display("FAIL rr_c_queued got count=%0d busy=%b exp 1/11", o_count, o_ch_busy); end
    step();
    total++; if (o_ch_start !== 2'b00 || o_count !== 3'd1 || o_ch_idxs !== mk(11)) begin bad++; $display("FAIL rr_hold got start=%b count=%0d exp 00/1 B held", o_ch_start, o_count); end
    i_ch_done = 2'b01; step(); i_ch_done = 2'b00;
    total++; if (o_ch_busy !== 2'b10 || o_ch_start !== 2'b00) begin bad++; $display("FAIL rr_done_edge got busy=%b start=%b exp 10/00", o_ch_busy, o_ch_start); end
    step();
    total++; if (o_ch_start !== 2'b01 || o_ch_idxs !== mk(12) || o_count !== 3'd0) begin bad++; $display("FAIL rr_c got start=%b count=%0d idxs=%h exp 01/0 C", o_ch_start, o_count, o_ch_idxs); end
  endtask

  task automatic test_overflow();
    do_reset();
    push_run(20, 25);
    total++; if (o_count !== 3'd4 || o_ready_to_rcv !== 1'b0) begin bad++; $display("FAIL ovf_full got count=%0d ready=%b exp 4/0", o_count, o_ready_to_rcv); end
    total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL ovf_not_yet got=%b exp=0", o_overflow); end
    push_run(26, 26);
    total++; if (o_overflow !== 1'b1 || o_count !== 3'd4) begin bad++; $display("FAIL ovf_drop got ovf=%b count=%0d exp 1/4", o_overflow, o_count); end
    step(); step();
    total++; if (o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", o_overflow); end
    // Drain to show the dropped set never entered the queue.
    i_ch_done = 2'b11; step(); i_ch_done = 2'b00;
    step();
    total++; if (o_ch_start !== 2'b01 || o_ch_idxs !== mk(22)) begin bad++; $display("FAIL ovf_order0 got start=%b idxs=%h exp 01 tag22", o_ch_start, o_ch_idxs); end
    step();
    total++; if (o_ch_start !== 2'b10 || o_ch_idxs !== mk(23) || o_count !== 3'd2) begin bad++; $display("FAIL ovf_order1 got start=%b count=%0d exp 10/2 tag23", o_ch_start, o_count); end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    push_run(30, 35);
    i_ch_done = 2'b01; step(); i_ch_done = 2'b00;
    total++; if (o_count !== 3'd4 || o_overflow !== 1'b0 || o_ch_busy !== 2'b10) begin bad++; $display("FAIL ppf_pre got count=%0d ovf=%b busy=%b exp 4/0/10", o_count, o_overflow, o_ch_busy); end
    i_idxs_ready = 1'b1; i_idxs = mk(39); step(); i_idxs_ready = 1'b0;
    total++; if (o_count !== 3'd3 || o_overflow !== 1'b1) begin bad++; $display("FAIL ppf_drop got count=%0d ovf=%b exp 3/1", o_count, o_overflow); end
    total++; if (o_ch_start !== 2'b01 || o_ch_idxs !== mk(32)) begin bad++; $display("FAIL ppf_pop got start=%b idxs=%h exp 01 tag32", o_ch_start, o_ch_idxs); end
    // Refill past the wrap point and drain; FIFO order must survive.
    push_run(40, 40);
    total++; if (o_count !== 3'd4) begin bad++; $display("FAIL ppf_refill got count=%0d exp 4", o_count); end
    i_ch_done = 2'b10; step(); i_ch_done = 2'b00;
    step();
    total++; if (o_ch_start !== 2'b10 || o_ch_idxs !== mk(33)) begin bad++; $display("FAIL ppf_order got start=%b idxs=%h exp 10 tag33", o_ch_start, o_ch_idxs); end
    for (int k = 0; k < 3; k++) begin
      i_ch_done = 2'b11; step(); i_ch_done = 2'b00;
      step();
    end
    total++; if (o_ch_idxs !== mk(40) || o_count !== 3'd0) begin bad++; $display("FAIL ppf_wrap got idxs=%h count=%0d exp tag40/0", o_ch_idxs, o_count); end
  endtask

  task automatic test_spurious_done();
    do_reset();
    total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL spur_ovf_cleared got=%b exp=0", o_overflow); end
    i_ch_done = 2'b10; step(); step(); i_ch_done = 2'b00;
    total++; if (o_ch_busy !== 2'b00 || o_ch_start !== 2'b00 || o_idle !== 1'b1 || o_count !== 3'd0) begin bad++; $display("FAIL spur_idle got busy=%b start=%b idle=%b exp 00/00/1", o_ch_busy, o_ch_start, o_idle); end
    push_run(50, 50);
    step();
    total++; if (o_ch_start !== 2'b01) begin bad++; $display("FAIL spur_start got=%b exp=01", o_ch_start); end
    i_ch_done = 2'b01; step(); i_ch_done = 2'b00;
    total++; if (o_ch_busy !== 2'b01) begin bad++; $display("FAIL spur_done_in_start got busy=%b exp=01", o_ch_busy); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    push_run(60, 64);
    total++; if (o_count !== 3'd3 || o_ch_busy !== 2'b11) begin bad++; $display("FAIL mid_pre got count=%0d busy=%b exp 3/11", o_count, o_ch_busy); end
    #2 rstn = 1'b0;
    #1;
    total++; if (o_count !== 3'd0 || o_ch_busy !== 2'b00 || o_ch_start !== 2'b00 || o_ch_idxs !== '0) begin bad++; $display("FAIL mid_async got count=%0d busy=%b start=%b exp all 0", o_count, o_ch_busy, o_ch_start); end
    step();
    rstn = 1'b1;
    step();
    total++; if (o_idle !== 1'b1 || o_ready_to_rcv !== 1'b1 || o_overflow !== 1'b0) begin bad++; $display("FAIL mid_after got idle=%b ready=%b ovf=%b exp 1/1/0", o_idle, o_ready_to_rcv, o_overflow); end
    push_run(65, 65);
    step();
    total++; if (o_ch_start !== 2'b01 || o_ch_idxs !== mk(65)) begin bad++; $display("FAIL mid_next_ch0 got start=%b idxs=%h exp 01 tag65", o_ch_start, o_ch_idxs); end
  endtask

  initial begin
    rstn         = 1'b0;
    i_idxs_ready = 1'b0;
    i_idxs       = '0;
    i_ch_done    = 2'b00;
    test_reset();
    test_single_job();
    test_round_robin();
    test_overflow();
    test_push_pop_full();
    test_spurious_done();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
